dma_fifo_ctrl: RTL and testbench

- Transfer engine that sits directly downstream of the DMA internal register block.
- Consumes that block's fifo_rd_enb/fifo_wr_enb and rd_inc*/wr_inc* qualifiers.
- Fetches beats from the memory read port into an internal FIFO and drains them to the memory write port.
- Returns fifo_wr/fifo_rd pulses with byte-step counts (dma_rd_addr_cnt/dma_wr_addr_cnt) so the register block can decrement its length register.

---
 rtl/dma_fifo_ctrl_pkg.sv | 37 +++
 rtl/dma_fifo_ctrl_if.sv | 51 +++++
 rtl/dma_fifo_ctrl_mem.sv | 64 ++++++
 rtl/dma_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_dma_fifo_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_fifo_ctrl_pkg.sv
// Purpose : shared widths, FSM state encodings and step helpers for the DMA FIFO controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: data_size, dma_fifo_depth, fifo_aw, read/write FSM enums, step constants, step_enc().
package dma_fifo_ctrl_pkg;

   localparam int data_size      = 32;
   localparam int dma_fifo_depth = 4;
   localparam int fifo_aw        = 3;
   localparam int fifo_depth     = 1 << fifo_aw;

   typedef logic [dma_fifo_depth-1:0] step_t;

   localparam step_t step_none = step_t'(0);
   localparam step_t step_byte = step_t'(1);
   localparam step_t step_half = step_t'(2);
   localparam step_t step_word = step_t'(4);

   typedef enum logic {
      R_IDLE = 1'b0,
      R_REQ  = 1'b1
   } rd_state_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_REQ  = 1'b1
   } wr_state_t;

   // Widest qualifier wins when the register block asserts more than one.
   function automatic step_t step_enc(input logic inc1, input logic inc2, input logic inc4);
      if (inc4)      return step_word;
      else if (inc2) return step_half;
      else if (inc1) return step_byte;
      else           return step_none;
   endfunction

endpackage

// File: rtl/dma_fifo_ctrl_if.sv
// Purpose : bundles the register-block qualifiers, memory read/write handshakes and FIFO status.
// Latency : n/a (wires only).
// Backpressure: n/a; slave = transfer engine view, master = environment view.
interface dma_fifo_ctrl_if;
   import dma_fifo_ctrl_pkg::*;

   // register block qualifiers
   logic                        fifo_rd_enb;
   logic                        fifo_wr_enb;
   logic                        rd_inc1;
   logic                        rd_inc2;
   logic                        rd_inc4;
   logic                        wr_inc1;
   logic                        wr_inc2;
   logic                        wr_inc4;
   // memory read port
   logic                        mem_rd_req;
   logic                        mem_rd_ack;
   logic [data_size-1:0]        mem_rd_data;
   // memory write port
   logic                        mem_wr_req;
   logic                        mem_wr_ack;
   logic [data_size-1:0]        mem_wr_data;
   // beat reports back to the register block and FIFO status
   logic                        fifo_wr;
   logic                        fifo_rd;
   logic [dma_fifo_depth-1:0]   dma_rd_addr_cnt;
   logic [dma_fifo_depth-1:0]   dma_wr_addr_cnt;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [fifo_aw:0]            fifo_level;

   modport slave (
      input  fifo_rd_enb, fifo_wr_enb,
      input  rd_inc1, rd_inc2, rd_inc4, wr_inc1, wr_inc2, wr_inc4,
      input  mem_rd_ack, mem_rd_data, mem_wr_ack,
      output mem_rd_req, mem_wr_req, mem_wr_data,
      output fifo_wr, fifo_rd, dma_rd_addr_cnt, dma_wr_addr_cnt,
      output fifo_full, fifo_empty, fifo_level
   );

   modport master (
      output fifo_rd_enb, fifo_wr_enb,
      output rd_inc1, rd_inc2, rd_inc4, wr_inc1, wr_inc2, wr_inc4,
      output mem_rd_ack, mem_rd_data, mem_wr_ack,
      input  mem_rd_req, mem_wr_req, mem_wr_data,
      input  fifo_wr, fifo_rd, dma_rd_addr_cnt, dma_wr_addr_cnt,
      input  fifo_full, fifo_empty, fifo_level
   );

endinterface

// File: rtl/dma_fifo_ctrl_mem.sv
// Purpose : 2**fifo_aw-entry storage with wrapping read/write pointers and registered level/full/empty.
// Latency : push visible in level/full/empty one edge later; head_data is a combinational read at rd_ptr.
// Backpressure: none here; the caller must not push when full or pop when empty.
// Ports   : clk, reset (async active-low), push/push_data, pop, head_data, level, full, empty.
module dma_fifo_mem
   import dma_fifo_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [data_size-1:0]  push_data,
   input  logic                  pop,
   output logic [data_size-1:0]  head_data,
   output logic [fifo_aw:0]      level,
   output logic                  full,
   output logic                  empty
);

   localparam logic [fifo_aw-1:0] ptr_one  = 1;
   localparam logic [fifo_aw:0]   lvl_one  = 1;
   localparam logic [fifo_aw:0]   lvl_full = (fifo_aw+1)'(fifo_depth);

   logic [data_size-1:0] mem_q [fifo_depth];
   logic [fifo_aw-1:0]   wr_ptr;
   logic [fifo_aw-1:0]   rd_ptr;
   logic [fifo_aw:0]     level_nxt;

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr] <= push_data;
   end

   assign head_data = mem_q[rd_ptr];

   always_comb begin
      level_nxt = level;
      case ({push, pop})
         2'b10:   level_nxt = level + lvl_one;
         2'b01:   level_nxt = level - lvl_one;
         default: level_nxt = level;
      endcase
   end

   // full/empty are registered from the next level so they line up with level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_one;
         if (pop)  rd_ptr <= rd_ptr + ptr_one;
         level <= level_nxt;
         full  <= (level_nxt == lvl_full);
         empty <= (level_nxt == '0);
      end
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: rtl/dma_fifo_ctrl.sv
// Purpose : fetches beats from the memory read port into a FIFO and drains them to the memory write port.
// Latency : req one edge after enable; fifo_wr/fifo_rd pulse the cycle after the matching ack; 2-cycle min beat.
// Backpressure: reads stall while full, writes stall while empty; requests hold until acked, never abort.
// Ports   : clk0, reset (async active-low), bus (dma_fifo_ctrl_if.slave: qualifiers, mem rd/wr, beat pulses, status).
module dma_fifo_ctrl
   import dma_fifo_ctrl_pkg::*;
(
   input  logic            clk0,
   input  logic            reset,
   dma_fifo_ctrl_if.slave  bus
);

   rd_state_t            rd_state, rd_state_nxt;
   wr_state_t            wr_state, wr_state_nxt;
   step_t                rd_step, wr_step;
   step_t                rd_step_q, wr_step_q;
   logic                 rd_start, wr_start;
   logic                 push, pop;
   logic                 fifo_wr_q, fifo_rd_q;
   step_t                rd_cnt_q, wr_cnt_q;
   logic [data_size-1:0] wr_data_q;
   logic [data_size-1:0] head_data;
   logic [fifo_aw:0]     level;
   logic                 full, empty;

   assign rd_step = step_enc(bus.rd_inc1, bus.rd_inc2, bus.rd_inc4);
   assign wr_step = step_enc(bus.wr_inc1, bus.wr_inc2, bus.wr_inc4);

   dma_fifo_mem u_mem (
      .clk       (clk0),
      .reset     (reset),
      .push      (push),
      .push_data (bus.mem_rd_data),
      .pop       (pop),
      .head_data (head_data),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   // Read side: only one read is ever outstanding, so checking full in idle is enough.
   always_comb begin
      rd_state_nxt = rd_state;
      rd_start     = 1'b0;
      push         = 1'b0;
      case (rd_state)
         R_IDLE: begin
            if (bus.fifo_rd_enb && (rd_step != step_none) && !full) begin
               rd_state_nxt = R_REQ;
               rd_start     = 1'b1;
            end
         end
         R_REQ: begin
            if (bus.mem_rd_ack) begin
               push         = 1'b1;
               rd_state_nxt = R_IDLE;
            end
         end
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   // Write side: the head entry is captured on entry so mem_wr_data is stable for the whole request.
   always_comb begin
      wr_state_nxt = wr_state;
      wr_start     = 1'b0;
      pop          = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (bus.fifo_wr_enb && (wr_step != step_none) && !empty) begin
               wr_state_nxt = W_REQ;
               wr_start     = 1'b1;
            end
         end
         W_REQ: begin
            if (bus.mem_wr_ack) begin
               pop          = 1'b1;
               wr_state_nxt = W_IDLE;
            end
         end
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk0 or negedge reset) begin
      if (!reset) begin
         rd_state  <= R_IDLE;
         wr_state  <= W_IDLE;
         rd_step_q <= step_none;
         wr_step_q <= step_none;
         fifo_wr_q <= 1'b0;
         fifo_rd_q <= 1'b0;
         rd_cnt_q  <= step_none;
         wr_cnt_q  <= step_none;
         wr_data_q <= '0;
      end else begin
         rd_state  <= rd_state_nxt;
         wr_state  <= wr_state_nxt;
         fifo_wr_q <= push;
         fifo_rd_q <= pop;
         if (rd_start) rd_step_q <= rd_step;
         if (wr_start) begin
            wr_step_q <= wr_step;
            wr_data_q <= head_data;
         end
         // Counts hold between pulses; the register block samples them only with the pulse.
         if (push) rd_cnt_q <= rd_step_q;
         if (pop)  wr_cnt_q <= wr_step_q;
      end
   end

   assign bus.mem_rd_req      = (rd_state == R_REQ);
   assign bus.mem_wr_req      = (wr_state == W_REQ);
   assign bus.mem_wr_data     = wr_data_q;
   assign bus.fifo_wr         = fifo_wr_q;
   assign bus.fifo_rd         = fifo_rd_q;
   assign bus.dma_rd_addr_cnt = rd_cnt_q;
   assign bus.dma_wr_addr_cnt = wr_cnt_q;
   assign bus.fifo_full       = full;
   assign bus.fifo_empty      = empty;
   assign bus.fifo_level      = level;

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Purpose : self-checking bench for dma_fifo_ctrl: step tables plus reset, fill, drain, overlap and wrap sequences.
// Latency : n/a.
// Backpressure: n/a.
module tb_dma_fifo_ctrl;
   import dma_fifo_ctrl_pkg::*;

   logic clk0 = 1'b0;
   logic reset;

   dma_fifo_ctrl_if bus();

   dma_fifo_ctrl dut (
      .clk0  (clk0),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk0 = ~clk0;

   typedef struct {
      logic        i1;
      logic        i2;
      logic        i4;
      logic [3:0]  step;
   } vec_t;

   int tests  = 0;
   int failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   // Waits for a read request, acks it after dly cycles, then checks the push report.
   task automatic read_beat(input logic [31:0] d, input int dly, input logic [3:0] step, input string nm);
      for (int i = 0; i < 200; i++) begin
         if (bus.mem_rd_req) break;
         tick();
      end
      check({nm, "_rd_req"}, bus.mem_rd_req, 1);
      if (!bus.mem_rd_req) return;
      repeat (dly) tick();
      bus.mem_rd_ack  = 1'b1;
      bus.mem_rd_data = d;
      tick();
      bus.mem_rd_ack  = 1'b0;
      bus.mem_rd_data = '0;
      check({nm, "_fifo_wr"}, bus.fifo_wr, 1);
      check({nm, "_rd_cnt"}, bus.dma_rd_addr_cnt, step);
   endtask

   // Waits for a write request, checks its data (also after the stall), acks, checks the pop report.
   task automatic write_beat(input logic [31:0] d, input int dly, input logic [3:0] step,
                             input bit toggle, input string nm);
      for (int i = 0; i < 200; i++) begin
         if (bus.mem_wr_req) break;
         tick();
      end
      check({nm, "_wr_req"}, bus.mem_wr_req, 1);
      if (!bus.mem_wr_req) return;
      check({nm, "_wr_data"}, bus.mem_wr_data, d);
      repeat (dly) begin
         if (toggle) bus.fifo_wr_enb = ~bus.fifo_wr_enb;
         tick();
      end
      check({nm, "_wr_hold"}, {bus.mem_wr_req, bus.mem_wr_data[30:0]}, {1'b1, d[30:0]});
      bus.mem_wr_ack = 1'b1;
      tick();
      bus.mem_wr_ack = 1'b0;
      check({nm, "_fifo_rd"}, bus.fifo_rd, 1);
      check({nm, "_wr_cnt"}, bus.dma_wr_addr_cnt, step);
   endtask

   task automatic set_rd_inc(input logic i1, input logic i2, input logic i4);
      bus.rd_inc1 = i1; bus.rd_inc2 = i2; bus.rd_inc4 = i4;
   endtask

   task automatic set_wr_inc(input logic i1, input logic i2, input logic i4);
      bus.wr_inc1 = i1; bus.wr_inc2 = i2; bus.wr_inc4 = i4;
   endtask

   vec_t rd_tab[8];
   vec_t wr_tab[9];

   initial begin
      logic       saw;
      int         k;
      logic [31:0] exp_d;

      // step tables: {inc1, inc2, inc4, expected step}
      rd_tab[0] = '{0,0,0,4'd0};  rd_tab[1] = '{1,0,0,4'd1};
      rd_tab[2] = '{0,1,0,4'd2};  rd_tab[3] = '{1,1,0,4'd2};
      rd_tab[4] = '{0,0,1,4'd4};  rd_tab[5] = '{1,0,1,4'd4};
      rd_tab[6] = '{0,1,1,4'd4};  rd_tab[7] = '{1,1,1,4'd4};
      wr_tab[0] = '{0,0,0,4'd0};  wr_tab[1] = '{1,0,0,4'd1};
      wr_tab[2] = '{0,1,0,4'd2};  wr_tab[3] = '{1,1,0,4'd2};
      wr_tab[4] = '{0,0,1,4'd4};  wr_tab[5] = '{1,0,1,4'd4};
      wr_tab[6] = '{0,1,1,4'd4};  wr_tab[7] = '{1,1,1,4'd4};
      wr_tab[8] = '{1,0,0,4'd1};

      reset = 1'b1;
      bus.fifo_rd_enb = 1'b0; bus.fifo_wr_enb = 1'b0;
      set_rd_inc(0,0,0); set_wr_inc(0,0,0);
      bus.mem_rd_ack = 1'b0; bus.mem_rd_data = '0; bus.mem_wr_ack = 1'b0;
      #2 reset = 1'b0;
      tick(); tick();

      // ---- reset state ----
      check("rst_reqs",   {bus.mem_rd_req, bus.mem_wr_req}, 0);
      check("rst_pulses", {bus.fifo_wr, bus.fifo_rd}, 0);
      check("rst_cnts",   {bus.dma_rd_addr_cnt, bus.dma_wr_addr_cnt}, 0);
      check("rst_status", {bus.fifo_full, bus.fifo_empty, bus.fifo_level}, {1'b0, 1'b1, 4'd0});
      check("rst_wr_data", bus.mem_wr_data, 0);
      #3 reset = 1'b1;
      tick();

      // ---- word read, ack two cycles after request ----
      bus.fifo_rd_enb = 1'b1; set_rd_inc(0,0,1);
      read_beat(32'hA5A5_0001, 2, 4'd4, "word");
      bus.fifo_rd_enb = 1'b0;
      check("word_level", {bus.fifo_empty, bus.fifo_level}, {1'b0, 4'd1});
      tick();
      check("word_single_pulse", bus.fifo_wr, 0);

      // ---- read-step table: 7 more pushes fill the FIFO ----
      for (int i = 0; i < 8; i++) begin
         set_rd_inc(rd_tab[i].i1, rd_tab[i].i2, rd_tab[i].i4);
         bus.fifo_rd_enb = 1'b1;
         if (rd_tab[i].step == 4'd0) begin
            saw = 1'b0;
            repeat (4) begin tick(); saw |= bus.mem_rd_req; end
            check("rdtab_zero_step_req", saw, 0);
         end else begin
            read_beat(32'h1000_0000 + i, i % 3, rd_tab[i].step, "rdtab");
         end
         bus.fifo_rd_enb = 1'b0;
      end
      check("rdtab_full", {bus.fifo_full, bus.fifo_level}, {1'b1, 4'd8});
      bus.fifo_rd_enb = 1'b1; set_rd_inc(0,0,1);
      saw = 1'b0;
      repeat (6) begin tick(); saw |= bus.mem_rd_req; end
      check("no_req_when_full", saw, 0);
      bus.fifo_rd_enb = 1'b0;

      // ---- write-step table drains in push order ----
      k = 0;
      for (int i = 0; i < 9; i++) begin
         set_wr_inc(wr_tab[i].i1, wr_tab[i].i2, wr_tab[i].i4);
         bus.fifo_wr_enb = 1'b1;
         if (wr_tab[i].step == 4'd0) begin
            saw = 1'b0;
            repeat (4) begin tick(); saw |= bus.mem_wr_req; end
            check("wrtab_zero_step_req", saw, 0);
         end else begin
            exp_d = (k == 0) ? 32'hA5A5_0001 : 32'h1000_0000 + k;
            write_beat(exp_d, i % 2, wr_tab[i].step, 1'b0, "wrtab");
            k++;
         end
         bus.fifo_wr_enb = 1'b0;
      end
      check("wrtab_empty", {bus.fifo_empty, bus.fifo_level}, {1'b1, 4'd0});

      // ---- fill with 8 back-to-back halfword reads ----
      bus.fifo_rd_enb = 1'b1; set_rd_inc(0,1,0);
      for (int i = 0; i < 8; i++) read_beat(32'h200 + i, i % 2, 4'd2, "fill");
      check("fill_full", {bus.fifo_full, bus.fifo_level}, {1'b1, 4'd8});
      saw = 1'b0;
      repeat (6) begin tick(); saw |= bus.mem_rd_req; end
      check("fill_no_9th", saw, 0);
      bus.fifo_rd_enb = 1'b0;
      bus.fifo_wr_enb = 1'b1; set_wr_inc(0,0,1);
      for (int i = 0; i < 8; i++) write_beat(32'h200 + i, i % 2, 4'd4, 1'b0, "fill_drain");
      bus.fifo_wr_enb = 1'b0;
      check("fill_drain_empty", bus.fifo_empty, 1);

      // ---- simultaneous push/pop at level 3, then byte drain ----
      bus.fifo_rd_enb = 1'b1; set_rd_inc(1,0,0);
      read_beat(32'h11, 0, 4'd1, "pre");
      read_beat(32'h22, 1, 4'd1, "pre");
      read_beat(32'h33, 0, 4'd1, "pre");
      bus.fifo_rd_enb = 1'b0;
      tick();
      check("pre_level", bus.fifo_level, 3);
      bus.fifo_rd_enb = 1'b1; set_rd_inc(0,0,1);
      bus.fifo_wr_enb = 1'b1; set_wr_inc(1,0,0);
      for (int i = 0; i < 20; i++) begin
         if (bus.mem_rd_req && bus.mem_wr_req) break;
         tick();
      end
      check("both_req", {bus.mem_rd_req, bus.mem_wr_req}, 2'b11);
      check("both_wr_data", bus.mem_wr_data, 32'h11);
      bus.mem_rd_ack = 1'b1; bus.mem_rd_data = 32'h44; bus.mem_wr_ack = 1'b1;
      tick();
      bus.mem_rd_ack = 1'b0; bus.mem_rd_data = '0; bus.mem_wr_ack = 1'b0;
      bus.fifo_rd_enb = 1'b0; bus.fifo_wr_enb = 1'b0;
      check("both_pulses", {bus.fifo_wr, bus.fifo_rd}, 2'b11);
      check("both_level", bus.fifo_level, 3);
      check("both_cnts", {bus.dma_rd_addr_cnt, bus.dma_wr_addr_cnt}, {4'd4, 4'd1});
      bus.fifo_wr_enb = 1'b1;
      write_beat(32'h22, 0, 4'd1, 1'b0, "drain");
      write_beat(32'h33, 2, 4'd1, 1'b0, "drain");
      write_beat(32'h44, 1, 4'd1, 1'b0, "drain");
      bus.fifo_wr_enb = 1'b0;
      tick();
      check("drain_empty", {bus.fifo_empty, bus.fifo_level}, {1'b1, 4'd0});

      // ---- asynchronous reset while a read is outstanding ----
      bus.fifo_rd_enb = 1'b1; set_rd_inc(0,0,1);
      read_beat(32'h55, 0, 4'd4, "prerst");
      for (int i = 0; i < 20; i++) begin
         if (bus.mem_rd_req) break;
         tick();
      end
      check("rst_mid_req_seen", bus.mem_rd_req, 1);
      #3 reset = 1'b0;
      #1;
      check("rst_mid_req", bus.mem_rd_req, 0);
      check("rst_mid_status", {bus.fifo_empty, bus.fifo_level}, {1'b1, 4'd0});
      bus.fifo_rd_enb = 1'b0;
      bus.mem_rd_ack  = 1'b1;
      tick();
      #3 reset = 1'b1;
      saw = 1'b0;
      repeat (4) begin tick(); saw |= bus.fifo_wr | bus.mem_rd_req; end
      bus.mem_rd_ack = 1'b0;
      check("rst_release_no_push", saw, 0);
      check("rst_release_level", bus.fifo_level, 0);

      // ---- 20 beats across pointer wrap with random stalls ----
      fork
         begin
            bus.fifo_rd_enb = 1'b1; set_rd_inc(0,0,1);
            for (int i = 0; i < 20; i++)
               read_beat(32'hC000_0000 + i, int'($urandom_range(0, 5)), 4'd4, "wrap");
            bus.fifo_rd_enb = 1'b0;
         end
         begin
            set_wr_inc(0,1,0);
            for (int j = 0; j < 20; j++) begin
               bus.fifo_wr_enb = 1'b1;
               write_beat(32'hC000_0000 + j, int'($urandom_range(0, 5)), 4'd2, 1'b1, "wrap");
            end
            bus.fifo_wr_enb = 1'b0;
         end
      join
      tick(); tick();
      check("wrap_final", {bus.fifo_empty, bus.fifo_level, bus.mem_rd_req, bus.mem_wr_req},
            {1'b1, 4'd0, 1'b0, 1'b0});

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
